// File: rtl/instruction_execute.sv
// instruction_execute: execute stage of the 3-bit processor.
// Drives the fetch pointer, executes the returned opcode/operand pair, updates
// A/B/C and emits values on a valid/ready stream.
// Optional feature macro: EXEC_ILLEGAL_TRAP_EN (combo operand 7 traps to ERROR).
module instruction_execute #(
    parameter int unsigned REG_W    = 32,
    parameter int unsigned PROG_LEN = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [REG_W-1:0] i_init_a,
    input  logic [2:0]       i_opcode,
    input  logic [2:0]       i_operand,
    output logic [3:0]       o_instr_ptr,
    output logic             o_halt,
    output logic             o_out_valid,
    output logic [2:0]       o_out_data,
    input  logic             i_out_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic [REG_W-1:0] o_reg_a,
    output logic [REG_W-1:0] o_reg_b,
    output logic [REG_W-1:0] o_reg_c
);

    localparam int unsigned      PTR_W     = 5;
    localparam logic [PTR_W-1:0] PTR_END   = PTR_W'(PROG_LEN);
    localparam logic [PTR_W-1:0] PTR_STEP  = PTR_W'(2);
    localparam logic [REG_W-1:0] SHIFT_LIM = REG_W'(REG_W);

    localparam logic [2:0] OP_ADV = 3'd0;
    localparam logic [2:0] OP_BXL = 3'd1;
    localparam logic [2:0] OP_BST = 3'd2;
    localparam logic [2:0] OP_JNZ = 3'd3;
    localparam logic [2:0] OP_BXC = 3'd4;
    localparam logic [2:0] OP_OUT = 3'd5;
    localparam logic [2:0] OP_BDV = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_OUT   = 3'd3,
`ifdef EXEC_ILLEGAL_TRAP_EN
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
`else
        S_DONE  = 3'd4
`endif
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_nxt;
    logic [PTR_W-1:0] w_ptr_adv;
    logic [REG_W-1:0] r_a, r_b, r_c;
    logic [REG_W-1:0] w_a_nxt, w_b_nxt, w_c_nxt;
    logic [2:0]       r_out_data;
    logic [2:0]       w_out_data_nxt;
    logic             r_out_valid;
    logic             r_halt;
    logic             r_busy;
    logic             r_done;
    logic [REG_W-1:0] w_combo;
    logic [REG_W-1:0] w_shift_res;
    logic             w_trap;

    // Combo operand decode and the shared A >> combo shifter.
    always_comb begin
        w_combo = '0;
        case (i_operand)
            3'd4:    w_combo = r_a;
            3'd5:    w_combo = r_b;
            3'd6:    w_combo = r_c;
            3'd7:    w_combo = '0;
            default: w_combo = REG_W'(i_operand);
        endcase
        w_shift_res = (w_combo >= SHIFT_LIM) ? '0 : (r_a >> w_combo);
    end

    // Reserved combo operand detection on combo-consuming opcodes.
    always_comb begin
        w_trap = 1'b0;
`ifdef EXEC_ILLEGAL_TRAP_EN
        if (i_operand == 3'd7) begin
            w_trap = (i_opcode == OP_ADV) || (i_opcode == OP_BST) ||
                     (i_opcode == OP_OUT) || (i_opcode == OP_BDV) ||
                     (i_opcode == 3'd7);
        end
`endif
    end

    // Next-state and next-datapath logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_a_nxt        = r_a;
        w_b_nxt        = r_b;
        w_c_nxt        = r_c;
        w_out_data_nxt = r_out_data;
        w_ptr_adv      = r_ptr + PTR_STEP;

        case (r_state)
            S_FETCH: begin
                w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (w_trap) begin
`ifdef EXEC_ILLEGAL_TRAP_EN
                    w_state_nxt = S_ERROR;
`endif
                end else begin
                    w_ptr_nxt = w_ptr_adv;
                    case (i_opcode)
                        OP_ADV:  w_a_nxt = w_shift_res;
                        OP_BXL:  w_b_nxt = r_b ^ REG_W'(i_operand);
                        OP_BST:  w_b_nxt = REG_W'(w_combo[2:0]);
                        OP_JNZ: begin
                            if (r_a != '0) begin
                                w_ptr_nxt = PTR_W'(i_operand);
                            end
                        end
                        OP_BXC:  w_b_nxt = r_b ^ r_c;
                        OP_OUT: begin
                            // Pointer advances only once the value is accepted.
                            w_out_data_nxt = w_combo[2:0];
                            w_ptr_nxt      = r_ptr;
                        end
                        OP_BDV:  w_b_nxt = w_shift_res;
                        default: w_c_nxt = w_shift_res;
                    endcase
                    if (i_opcode == OP_OUT) begin
                        w_state_nxt = S_OUT;
                    end else if (w_ptr_nxt >= PTR_END) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            S_OUT: begin
                if (i_out_ready) begin
                    w_ptr_nxt   = w_ptr_adv;
                    w_state_nxt = (w_ptr_adv >= PTR_END) ? S_DONE : S_FETCH;
                end
            end
            default: begin
                // IDLE, DONE and ERROR accept a new run.
                if (i_start) begin
                    w_state_nxt = S_FETCH;
                    w_ptr_nxt   = '0;
                    w_a_nxt     = i_init_a;
                    w_b_nxt     = '0;
                    w_c_nxt     = '0;
                end
            end
        endcase
    end

    // State, datapath and output registers; flags decoded from next state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_halt      <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_a         <= w_a_nxt;
            r_b         <= w_b_nxt;
            r_c         <= w_c_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= (w_state_nxt == S_OUT);
            r_halt      <= (w_state_nxt != S_FETCH);
            r_busy      <= (w_state_nxt == S_FETCH) || (w_state_nxt == S_EXEC) ||
                           (w_state_nxt == S_OUT);
            r_done      <= (w_state_nxt == S_DONE);
        end
    end

    assign o_instr_ptr = r_ptr[3:0];
    assign o_halt      = r_halt;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_reg_a     = r_a;
    assign o_reg_b     = r_b;
    assign o_reg_c     = r_c;

endmodule

// File: tb/tb_instruction_execute.sv
// Directed testbench for instruction_execute with a registered fetch model
// (zero-padded program ROM, odd pointers return 0/0) and an output collector.
module tb_instruction_execute;

    localparam int unsigned REG_W    = 32;
    localparam int unsigned PROG_LEN = 6;

    logic             clk;
    logic             rst;
    logic             start;
    logic [REG_W-1:0] init_a;
    logic [2:0]       opcode;
    logic [2:0]       operand;
    logic [3:0]       instr_ptr;
    logic             halt;
    logic             out_valid;
    logic [2:0]       out_data;
    logic             out_ready;
    logic             busy;
    logic             done;
    logic [REG_W-1:0] reg_a, reg_b, reg_c;

    int n_checks = 0;
    int n_errors = 0;

    logic [2:0] rom [16];
    logic [2:0] got_q [$];

    instruction_execute #(.REG_W(REG_W), .PROG_LEN(PROG_LEN)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_init_a    (init_a),
        .i_opcode    (opcode),
        .i_operand   (operand),
        .o_instr_ptr (instr_ptr),
        .o_halt      (halt),
        .o_out_valid (out_valid),
        .o_out_data  (out_data),
        .i_out_ready (out_ready),
        .o_busy      (busy),
        .o_done      (done),
        .o_reg_a     (reg_a),
        .o_reg_b     (reg_b),
        .o_reg_c     (reg_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fetch stage model: captures the pair at the edge ending a non-halted cycle.
    always @(posedge clk) begin
        if (rst) begin
            opcode  <= 3'd0;
            operand <= 3'd0;
        end else if (!halt) begin
            if (instr_ptr[0]) begin
                opcode  <= 3'd0;
                operand <= 3'd0;
            end else begin
                opcode  <= rom[int'(instr_ptr)];
                operand <= rom[int'(instr_ptr) + 1];
            end
        end
    end

    // Output stream collector.
    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) got_q.push_back(out_data);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Program words in order p0..p5 as six octal digits.
    task automatic set_prog(input logic [17:0] words);
        for (int i = 0; i < 16; i++) rom[i] = 3'd0;
        for (int i = 0; i < 6; i++) rom[i] = words[17 - 3*i -: 3];
    endtask

    task automatic pulse_start(input logic [31:0] a);
        @(negedge clk);
        init_a = a;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n = 0;
        while (busy && n < max) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle_timeout"}, 32'(busy), 0);
    endtask

    task automatic wait_valid(input string tag, input int max);
        int n = 0;
        while (!out_valid && n < max) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid_timeout"}, 32'(out_valid), 1);
    endtask

    int exp3 [11] = '{4, 2, 5, 6, 7, 7, 7, 7, 3, 1, 0};

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        init_a    = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) rom[i] = 3'd0;
        repeat (2) @(negedge clk);

        // Reset values
        check("rst_a", reg_a, 0);
        check("rst_b", reg_b, 0);
        check("rst_c", reg_c, 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_halt", 32'(halt), 1);
        check("rst_ptr", 32'(instr_ptr), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 0);

        // bst 4 with start held into FETCH (second start ignored)
        set_prog(18'o240000);
        got_q.delete();
        init_a = 32'd10;
        start  = 1'b1;
        @(negedge clk);
        check("t1_fetch_halt", 32'(halt), 0);
        check("t1_fetch_busy", 32'(busy), 1);
        check("t1_fetch_ptr", 32'(instr_ptr), 0);
        init_a = 32'd99;
        @(negedge clk);
        start = 1'b0;
        check("t1_exec_halt", 32'(halt), 1);
        check("t1_exec_busy", 32'(busy), 1);
        @(negedge clk);
        check("t1_b_visible", reg_b, 2);
        check("t1_next_ptr", 32'(instr_ptr), 2);
        check("t1_next_halt", 32'(halt), 0);
        wait_idle("t1", 50);
        check("t1_done", 32'(done), 1);
        check("t1_a", reg_a, 10);
        check("t1_b", reg_b, 2);
        check("t1_nout", got_q.size(), 0);

        // out 0, out 1, out A
        set_prog(18'o505154);
        got_q.delete();
        out_ready = 1'b1;
        pulse_start(32'd10);
        wait_idle("t2", 100);
        check("t2_done", 32'(done), 1);
        check("t2_a", reg_a, 10);
        check("t2_nout", got_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < got_q.size()) check($sformatf("t2_out%0d", i), 32'(got_q[i]), i);
        end

        // adv 1 / out A / jnz 0 loop
        set_prog(18'o015430);
        got_q.delete();
        pulse_start(32'd2024);
        wait_idle("t3", 400);
        check("t3_done", 32'(done), 1);
        check("t3_a", reg_a, 0);
        check("t3_nout", got_q.size(), 11);
        for (int i = 0; i < 11; i++) begin
            if (i < got_q.size()) check($sformatf("t3_out%0d", i), 32'(got_q[i]), exp3[i]);
        end

        // Backpressure in OUT
        set_prog(18'o540000);
        got_q.delete();
        out_ready = 1'b0;
        pulse_start(32'd10);
        wait_valid("t4", 20);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("t4_valid%0d", i), 32'(out_valid), 1);
            check($sformatf("t4_data%0d", i), 32'(out_data), 2);
            check($sformatf("t4_ptr%0d", i), 32'(instr_ptr), 0);
            check($sformatf("t4_halt%0d", i), 32'(halt), 1);
            check($sformatf("t4_a%0d", i), reg_a, 10);
        end
        check("t4_nout_held", got_q.size(), 0);
        out_ready = 1'b1;
        @(negedge clk);
        check("t4_valid_drop", 32'(out_valid), 0);
        check("t4_ptr_adv", 32'(instr_ptr), 2);
        wait_idle("t4", 50);
        check("t4_done", 32'(done), 1);
        check("t4_nout", got_q.size(), 1);
        if (got_q.size() > 0) check("t4_out0", 32'(got_q[0]), 2);

        // Reset while in OUT drops the pending output
        got_q.delete();
        out_ready = 1'b0;
        pulse_start(32'd10);
        wait_valid("t5", 20);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_valid", 32'(out_valid), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_done", 32'(done), 0);
        check("t5_halt", 32'(halt), 1);
        check("t5_ptr", 32'(instr_ptr), 0);
        check("t5_a", reg_a, 0);
        check("t5_data", 32'(out_data), 0);
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("t5_nout", got_q.size(), 0);
        check("t5_still_idle", 32'(busy), 0);

        // Shift by A (40 >= REG_W) clears A
        set_prog(18'o040000);
        pulse_start(32'd40);
        wait_idle("t6", 50);
        check("t6_done", 32'(done), 1);
        check("t6_a", reg_a, 0);

        // Reserved combo operand 7
        set_prog(18'o070000);
        got_q.delete();
        pulse_start(32'd5);
        wait_idle("t7", 50);
        check("t7_a", reg_a, 5);
        check("t7_nout", got_q.size(), 0);
`ifdef EXEC_ILLEGAL_TRAP_EN
        check("t7_done", 32'(done), 0);
        check("t7_ptr", 32'(instr_ptr), 0);
        pulse_start(32'd7);
        check("t7_restart_busy", 32'(busy), 1);
        wait_idle("t7r", 50);
        check("t7_restart_a", reg_a, 7);
`else
        check("t7_done", 32'(done), 1);
        check("t7_ptr", 32'(instr_ptr), 6);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
